vs_product_memory: RTL and testbench
====================================

# vs_product_memory

Storage-side responder for the inner-product transfer path. It absorbs the single-word write bursts that the sensing-matrix processor issues on `prod_write_enable`/`write_addr`/`write_data`. It serves the address/data read port used by the max identifier with one-cycle read latency. It tracks which entries hold fresh products, so downstream logic knows when a batch, and the whole product vector, is complete.

## Interface
Parameters:
- `COLUMNS`, default 256. Number of product entries; must be ≤ 256.
- `BATCH_SIZE`, default 64. Entries per batch; must divide `COLUMNS`.
- `BATCHES`, default COLUMNS/BATCH_SIZE. Derived; do not override.

Ports:
- `clock`  in  1. Single clock; all logic is rising-edge.
- `reset_n`  in  1. Reset, synchronous and active-low.
- `prod_write_enable`  in  1. Write strobe, one word per cycle.
- `write_addr`  in  8. Write address.
- `write_data`  in  FP_DATA_BUS_WIDTH. Product word (fp_32_t).
- `read_addr`  in  8. Read address.
- `read_data`  out  FP_DATA_BUS_WIDTH. Data for the `read_addr` presented in the previous cycle.
- `read_miss`  out  1. Aligned with `read_data`; the entry read was not valid.
- `clear`  in  1. Invalidate all entries; start a new product vector.
- `batch_ready`  out  1. One-cycle pulse when a batch becomes fully valid.
- `batch_index`  out  8. Batch number qualified by `batch_ready`.
- `entries_valid`  out  9. Count of valid entries, 0..COLUMNS.
- `all_valid`  out  1. Level; `entries_valid == COLUMNS`.
- `overwrite`  out  1. One-cycle pulse; a write hit an already-valid entry.

## Operation
- Storage: `COLUMNS` × fp_32_t array, a `COLUMNS`-bit valid bitmap, and one per-batch fill counter (0..BATCH_SIZE) per batch.
- Write (`prod_write_enable`=1, `write_addr` < COLUMNS):
  - The word is stored.
  - If the entry was invalid: set its valid bit, increment `entries_valid`, and increment the fill counter of batch `write_addr / BATCH_SIZE`.
  - When that counter reaches BATCH_SIZE, pulse `batch_ready` with `batch_index` next cycle.
  - If the entry was already valid: the data is replaced, no counts change, and `overwrite` pulses.
- Out-of-range write (`write_addr` ≥ COLUMNS): ignored, with no state change and no pulse.
- Read: every cycle, the registered `read_addr` selects the word and valid bit. `read_data` is 0 and `read_miss`=1 when the entry is invalid or the address is ≥ COLUMNS.
- Fill-state machine:
  - EMPTY → FILLING on the first valid new write.
  - FILLING → FULL when `entries_valid` reaches COLUMNS.
  - Any state → EMPTY on `clear`.
  - `all_valid` = (state == FULL).
- `clear` and a write in the same cycle: clear is applied first, then the write. Result: that entry is valid, `entries_valid`=1, state FILLING, and its batch counter=1.
- Read-after-write to the same address in the same cycle: see Configuration.

## Timing
- Reset values (cycle after `reset_n` sampled low): `read_data`=0, `read_miss`=0, `batch_ready`=0, `batch_index`=0, `entries_valid`=0, `all_valid`=0, `overwrite`=0, state EMPTY, bitmap and counters cleared.
- Reset does not clear array contents. Reset asserted mid-burst drops the in-flight write.
- Read latency is 1 cycle: an address at edge N gives data valid after edge N+1.
- Status latency is 1 cycle. A write at edge N updates `entries_valid`, `overwrite` and `batch_ready`/`batch_index` after edge N; `all_valid` is updated at the same edge.
- Sustains one write plus one read per cycle indefinitely, with no backpressure.
- `batch_ready` pulses are at most one per cycle, in completion order (not index order).
- A `clear` at edge N: all status outputs read 0 after edge N, except where a same-cycle write applies.

## Configuration
- `VS_PRODUCT_MEM_BYPASS_EN` defined:
  - A read and write to the same valid-range address in the same cycle returns the new `write_data`, with `read_miss`=0.
- Undefined:
  - The read returns the prior contents and prior valid bit (read-before-write).
  - Only the read path differs; write-side status is identical in both builds.

## Test plan
- Reset, then read addresses 0..3 → `read_data`=0, `read_miss`=1 each, `entries_valid`=0, `all_valid`=0.
- Burst-write addresses 0..63 with data = addr+100 (BATCH_SIZE=64):
  - `batch_ready` pulses once with `batch_index`=0 the cycle after address 63 is written.
  - Reading address 10 gives 110 after 1 cycle.
- Write all 256 entries in the order batch 3, 1, 0, 2:
  - `batch_ready` indices arrive 3, 1, 0, 2.
  - `all_valid` rises after the last write.
  - `entries_valid`=256.
- Rewrite address 5 with 7:
  - `overwrite` pulses.
  - `entries_valid` stays the same.
  - No `batch_ready` pulse.
  - A read returns 7.
- Same-cycle write addr 20 = 0x1234 and read addr 20, with the entry previously 0x0001:
  - Macro defined → 0x1234.
  - Macro undefined → 0x0001.
- Assert `clear` together with a write to address 200:
  - Next cycle `entries_valid`=1, state FILLING.
  - A read of address 0 misses; a read of address 200 hits.
  - `reset_n` low mid-burst → all status outputs 0 next cycle.

Source files
------------

// File: rtl/vs_product_memory.sv
// Product store for the inner-product path: COLUMNS words, valid bitmap, per-batch fill tracking.
// Latency: read data and all status outputs are registered, one cycle after the inputs are sampled.
// Backpressure: none; one write and one read are accepted every cycle.
// Optional VS_PRODUCT_MEM_BYPASS_EN: same-cycle read of the address being written returns the new word.
module vs_product_memory #(
  parameter int COLUMNS           = 256,
  parameter int BATCH_SIZE        = 64,
  parameter int BATCHES           = COLUMNS / BATCH_SIZE,
  parameter int FP_DATA_BUS_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         prod_write_enable,
  input  logic [7:0]                   write_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0] write_data,
  input  logic [7:0]                   read_addr,
  output logic [FP_DATA_BUS_WIDTH-1:0] read_data,
  output logic                         read_miss,
  input  logic                         clear,
  output logic                         batch_ready,
  output logic [7:0]                   batch_index,
  output logic [8:0]                   entries_valid,
  output logic                         all_valid,
  output logic                         overwrite
);

  typedef logic [FP_DATA_BUS_WIDTH-1:0] fp_32_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL} state_t;

  localparam int         AW    = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int         BW    = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam int         CW    = $clog2(BATCH_SIZE + 1);
  localparam logic [8:0] COLS9 = 9'(COLUMNS);

  fp_32_t           mem_q [COLUMNS];
  logic [COLUMNS-1:0] valid_q;
  logic [CW-1:0]    fill_q [BATCHES];
  logic [8:0]       entries_q, entries_d;
  state_t           state_q, state_d;
  logic             batch_ready_q, overwrite_q;
  logic [7:0]       batch_index_q;
  fp_32_t           rd_data_q, rd_data_d;
  logic             rd_miss_q, rd_miss_d;

  logic [AW-1:0]    wa_idx, ra_idx;
  logic [7:0]       wr_batch;
  logic [BW-1:0]    wb_idx;
  logic             wr_ok, was_valid, new_write, batch_done, rd_in_range;
  logic [CW-1:0]    cnt_new;

  assign wa_idx   = write_addr[AW-1:0];
  assign ra_idx   = read_addr[AW-1:0];
  assign wr_batch = 8'(int'(write_addr) / BATCH_SIZE);
  assign wb_idx   = wr_batch[BW-1:0];

  // Write-side decode: clear is applied before a same-cycle write, so the write sees an empty vector.
  always_comb begin
    wr_ok      = prod_write_enable && ({1'b0, write_addr} < COLS9);
    was_valid  = !clear && valid_q[wa_idx];
    new_write  = wr_ok && !was_valid;
    cnt_new    = (clear ? '0 : fill_q[wb_idx]) + CW'(1);
    batch_done = new_write && (cnt_new == CW'(BATCH_SIZE));
    entries_d  = (clear ? 9'd0 : entries_q) + 9'(new_write);
    if (entries_d == COLS9) begin
      state_d = ST_FULL;
    end else if (entries_d != 9'd0) begin
      state_d = ST_FILLING;
    end else begin
      state_d = ST_EMPTY;
    end
  end

  // Read-side select: prior contents by default, optionally forwarding the word being written.
  always_comb begin
    rd_in_range = ({1'b0, read_addr} < COLS9);
    rd_data_d   = '0;
    rd_miss_d   = 1'b1;
    if (rd_in_range && valid_q[ra_idx]) begin
      rd_data_d = mem_q[ra_idx];
      rd_miss_d = 1'b0;
    end
`ifdef VS_PRODUCT_MEM_BYPASS_EN
    if (rd_in_range && wr_ok && (write_addr == read_addr)) begin
      rd_data_d = write_data;
      rd_miss_d = 1'b0;
    end
`endif
  end

  // Data array: not reset, but a write sampled while reset is asserted is dropped.
  always_ff @(posedge clock) begin
    if (reset_n && wr_ok) begin
      mem_q[wa_idx] <= write_data;
    end
  end

  // Fill-state machine with bitmap, batch counters and registered status pulses.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_EMPTY;
      entries_q     <= '0;
      valid_q       <= '0;
      batch_ready_q <= 1'b0;
      batch_index_q <= '0;
      overwrite_q   <= 1'b0;
      for (int i = 0; i < BATCHES; i++) begin
        fill_q[i] <= '0;
      end
    end else begin
      if (clear) begin
        valid_q <= '0;
        for (int i = 0; i < BATCHES; i++) begin
          fill_q[i] <= '0;
        end
      end
      if (new_write) begin
        valid_q[wa_idx] <= 1'b1;
        fill_q[wb_idx]  <= cnt_new;
      end
      state_q       <= state_d;
      entries_q     <= entries_d;
      overwrite_q   <= wr_ok && was_valid;
      batch_ready_q <= batch_done;
      if (batch_done) begin
        batch_index_q <= wr_batch;
      end else if (clear) begin
        batch_index_q <= '0;
      end
    end
  end

  // Read output register: one-cycle latency from read_addr.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_data_q <= '0;
      rd_miss_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_miss_q <= rd_miss_d;
    end
  end

  assign read_data     = rd_data_q;
  assign read_miss     = rd_miss_q;
  assign batch_ready   = batch_ready_q;
  assign batch_index   = batch_index_q;
  assign entries_valid = entries_q;
  assign all_valid     = (state_q == ST_FULL);
  assign overwrite     = overwrite_q;

endmodule

// File: tb/tb_vs_product_memory.sv
// Directed bench for vs_product_memory with a read scoreboard and a behavioural status model.
module tb_vs_product_memory;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        prod_write_enable;
  logic [7:0]  write_addr;
  logic [31:0] write_data;
  logic [7:0]  read_addr;
  logic [31:0] read_data;
  logic        read_miss;
  logic        clear;
  logic        batch_ready;
  logic [7:0]  batch_index;
  logic [8:0]  entries_valid;
  logic        all_valid;
  logic        overwrite;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the product vector
  logic [31:0] mm [256];
  logic [255:0] mv;
  int fill [4];
  int ent;
  logic [32:0] rd_q [$];
  int obs_bi [$];

  vs_product_memory dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .prod_write_enable (prod_write_enable),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .read_addr         (read_addr),
    .read_data         (read_data),
    .read_miss         (read_miss),
    .clear             (clear),
    .batch_ready       (batch_ready),
    .batch_index       (batch_index),
    .entries_valid     (entries_valid),
    .all_valid         (all_valid),
    .overwrite         (overwrite)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    mv  = '0;
    ent = 0;
    for (int i = 0; i < 4; i++) fill[i] = 0;
  endtask

  // One clock of stimulus: predict read result and status, drive, then compare.
  task automatic cyc(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                     input logic [7:0] ra, input logic clr);
    logic [31:0] ed;
    logic        em;
    logic        exp_ov;
    logic        exp_br;
    logic [7:0]  exp_bi;
    logic [32:0] e;
    int          b;
    em = !mv[ra];
    ed = mv[ra] ? mm[ra] : 32'h0;
`ifdef VS_PRODUCT_MEM_BYPASS_EN
    if (we && (wa == ra)) begin
      ed = wd;
      em = 1'b0;
    end
`endif
    rd_q.push_back({em, ed});
    if (clr) model_reset();
    exp_ov = 1'b0;
    exp_br = 1'b0;
    exp_bi = 8'h0;
    if (we) begin
      b = int'(wa) / 64;
      if (mv[wa]) begin
        exp_ov = 1'b1;
      end else begin
        mv[wa] = 1'b1;
        ent++;
        fill[b]++;
        if (fill[b] == 64) begin
          exp_br = 1'b1;
          exp_bi = 8'(b);
        end
      end
      mm[wa] = wd;
    end
    prod_write_enable = we;
    write_addr        = wa;
    write_data        = wd;
    read_addr         = ra;
    clear             = clr;
    tick();
    prod_write_enable = 1'b0;
    clear             = 1'b0;
    e = rd_q.pop_front();
    check("read_data", read_data, e[31:0]);
    check("read_miss", 32'(read_miss), 32'(e[32]));
    check("entries_valid", 32'(entries_valid), 32'(ent));
    check("overwrite", 32'(overwrite), 32'(exp_ov));
    check("batch_ready", 32'(batch_ready), 32'(exp_br));
    check("all_valid", 32'(all_valid), 32'(ent == 256));
    if (exp_br) check("batch_index", 32'(batch_index), 32'(exp_bi));
    if (batch_ready) obs_bi.push_back(int'(batch_index));
  endtask

  task automatic do_reset(input int n, input logic we, input logic [7:0] wa, input logic [31:0] wd);
    reset_n           = 1'b0;
    prod_write_enable = we;
    write_addr        = wa;
    write_data        = wd;
    read_addr         = 8'h0;
    clear             = 1'b0;
    for (int i = 0; i < n; i++) tick();
    prod_write_enable = 1'b0;
    model_reset();
    check("rst_read_data", read_data, 32'h0);
    check("rst_read_miss", 32'(read_miss), 32'h0);
    check("rst_batch_ready", 32'(batch_ready), 32'h0);
    check("rst_batch_index", 32'(batch_index), 32'h0);
    check("rst_entries_valid", 32'(entries_valid), 32'h0);
    check("rst_all_valid", 32'(all_valid), 32'h0);
    check("rst_overwrite", 32'(overwrite), 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    int ord [4] = '{3, 1, 0, 2};
    int n_bi;
    int a;

    // Reset with idle inputs
    do_reset(3, 1'b0, 8'h0, 32'h0);

    // Reads of an empty vector miss
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h0, 32'h0, 8'(i), 1'b0);

    // Batch 0 burst, data = addr + 100, reading the previous address alongside
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 32'(i + 100), 8'(i == 0 ? 0 : i - 1), 1'b0);
    cyc(1'b0, 8'h0, 32'h0, 8'd10, 1'b0);
    check("rd10_value", read_data, 32'd110);
    check("batch0_pulses", 32'(obs_bi.size()), 32'd1);
    if (obs_bi.size() > 0) check("batch0_index", 32'(obs_bi[0]), 32'd0);

    // Fresh vector, fill batches in order 3,1,0,2 reading the address being written
    cyc(1'b0, 8'h0, 32'h0, 8'h0, 1'b1);
    obs_bi.delete();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 64; j++) begin
        a = ord[k] * 64 + j;
        cyc(1'b1, 8'(a), 32'hA5A5_0000 | 32'(a), 8'(a), 1'b0);
      end
    end
    check("order_count", 32'(obs_bi.size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_bi.size(); k++) check("order_index", 32'(obs_bi[k]), 32'(ord[k]));
    check("full_entries", 32'(entries_valid), 32'd256);
    check("full_all_valid", 32'(all_valid), 32'd1);

    // Overwrite address 5 with 7
    n_bi = obs_bi.size();
    cyc(1'b1, 8'd5, 32'd7, 8'd9, 1'b0);
    cyc(1'b0, 8'h0, 32'h0, 8'd5, 1'b0);
    check("rd5_value", read_data, 32'd7);
    check("ovw_no_batch", 32'(obs_bi.size()), 32'(n_bi));

    // Same-cycle read and write of address 20
    cyc(1'b1, 8'd20, 32'h0001, 8'd0, 1'b0);
    cyc(1'b1, 8'd20, 32'h1234, 8'd20, 1'b0);
    cyc(1'b0, 8'h0, 32'h0, 8'd20, 1'b0);
    check("rd20_after", read_data, 32'h1234);

    // Clear together with a write to 200
    cyc(1'b1, 8'd200, 32'h0000_CAFE, 8'd0, 1'b1);
    check("clr_entries", 32'(entries_valid), 32'd1);
    check("clr_batch_index", 32'(batch_index), 32'h0);
    cyc(1'b0, 8'h0, 32'h0, 8'd0, 1'b0);
    check("clr_rd0_miss", 32'(read_miss), 32'd1);
    cyc(1'b0, 8'h0, 32'h0, 8'd200, 1'b0);
    check("clr_rd200_hit", 32'(read_miss), 32'd0);

    // Reset in the middle of a burst drops the in-flight write
    cyc(1'b1, 8'd201, 32'd1, 8'd0, 1'b0);
    cyc(1'b1, 8'd202, 32'd2, 8'd0, 1'b0);
    do_reset(1, 1'b1, 8'd203, 32'd3);
    cyc(1'b0, 8'h0, 32'h0, 8'd203, 1'b0);
    cyc(1'b0, 8'h0, 32'h0, 8'd201, 1'b0);
    cyc(1'b1, 8'd64, 32'd64, 8'd64, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
